tone_detector: RTL and testbench

TONE_DETECTOR -- requirements
Module: tone_detector

---
 rtl/tone_pkg.sv | 41 ++++
 rtl/tone_period_meter.sv | 50 +++++
 rtl/tone_detector.sv | 172 +++++++++++++++++
 tb/tb_tone_detector.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared note definitions for the tone generator and tone detector:
// note-index encoding, note frequencies and the clock-derived period table.
package tone_pkg;

  localparam int unsigned NUM_NOTES = 16;

  // Note index encoding, C4 .. D6 (diatonic, ascending)
  typedef enum logic [3:0] {
    NOTE_C4, NOTE_D4, NOTE_E4, NOTE_F4, NOTE_G4, NOTE_A4, NOTE_B4, NOTE_C5,
    NOTE_D5, NOTE_E5, NOTE_F5, NOTE_G5, NOTE_A5, NOTE_B5, NOTE_C6, NOTE_D6
  } note_e;

  // Nominal frequency of each note index in Hz
  function automatic int unsigned note_freq(input int unsigned idx);
    case (idx)
      0:       note_freq = 262;
      1:       note_freq = 294;
      2:       note_freq = 330;
      3:       note_freq = 349;
      4:       note_freq = 392;
      5:       note_freq = 440;
      6:       note_freq = 494;
      7:       note_freq = 523;
      8:       note_freq = 587;
      9:       note_freq = 659;
      10:      note_freq = 698;
      11:      note_freq = 784;
      12:      note_freq = 880;
      13:      note_freq = 988;
      14:      note_freq = 1047;
      default: note_freq = 1175;
    endcase
  endfunction

  // Period of a note in clock cycles (truncating division)
  function automatic logic [31:0] note_period(input int unsigned clock_freq,
                                              input int unsigned idx);
    note_period = 32'(clock_freq / note_freq(idx));
  endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Front end of the tone detector: 2-FF synchronizer, rising-edge detect,
// free-running period counter that restarts on every edge, and the
// silence timeout. In the cycle after an edge the counter reads 1, so on
// the next edge-detect cycle it holds exactly the edge-to-edge distance.
module tone_period_meter #(
  parameter int unsigned TIMEOUT = 91602
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        audio_in,
  output logic        edge_det,
  output logic [31:0] period,
  output logic        timeout
);

  logic        sync1_reg;
  logic        sync2_reg;
  logic        prev_reg;
  logic [31:0] count_reg;

  // Synchronize the asynchronous input and keep one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= audio_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign edge_det = sync2_reg & ~prev_reg;
  assign period   = count_reg;
  // Fires on the cycle whose increment brings the counter to TIMEOUT
  assign timeout  = ~edge_det && (count_reg == TIMEOUT - 1);

  // Period counter: restart on each edge, saturate at TIMEOUT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= 32'd0;
    end else if (edge_det) begin
      count_reg <= 32'd1;
    end else if (count_reg < TIMEOUT) begin
      count_reg <= count_reg + 32'd1;
    end
  end

endmodule

// File: rtl/tone_detector.sv
// Tone detector: measures the input period, scans the 16-entry period table
// one entry per cycle for the nearest note, then accepts or rejects the
// candidate and debounces it over STABLE_COUNT consecutive matches.
module tone_detector
  import tone_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ   = 12000000,
  parameter int unsigned STABLE_COUNT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        audio_in,
  output logic [3:0]  note_sel,
  output logic        note_valid,
  output logic        note_change,
  output logic        silence,
  output logic [31:0] period_meas
);

  localparam logic [31:0] MIN_PERIOD = note_period(CLOCK_FREQ, NUM_NOTES - 1) >> 1;
  localparam int unsigned TIMEOUT    = 2 * note_period(CLOCK_FREQ, 0);
  localparam logic [3:0]  LAST_IDX   = 4'(NUM_NOTES - 1);
  localparam logic [7:0]  STAB_MAX   = 8'(STABLE_COUNT);

  typedef enum logic [1:0] {WAIT_EDGE, MEASURE, CLASSIFY, DECIDE} state_t;

  logic        edge_det;
  logic [31:0] meter_period;
  logic        timeout;

  tone_period_meter #(.TIMEOUT(TIMEOUT)) u_meter (
    .clk      (clk),
    .rst_n    (rst_n),
    .audio_in (audio_in),
    .edge_det (edge_det),
    .period   (meter_period),
    .timeout  (timeout)
  );

  // Period table, constant-folded from the clock frequency
  logic [31:0] period_tab [NUM_NOTES];
  for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_tab
    assign period_tab[gi] = note_period(CLOCK_FREQ, gi);
  end

  state_t      state_reg, state_next;
  logic [3:0]  idx_reg, idx_next;
  logic [31:0] period_reg, period_next;
  logic [31:0] min_reg, min_next;
  logic [3:0]  best_reg, best_next;
  logic [3:0]  cand_reg, cand_next;
  logic [7:0]  stab_reg, stab_next;
  logic [3:0]  sel_next;
  logic        valid_next, change_next, silence_next;
  logic [31:0] meas_next;
  logic [31:0] tab_entry, diff;
  logic [7:0]  stab_cnt;
  logic        accept;

  assign tab_entry = period_tab[idx_reg];
  assign diff      = (period_reg >= tab_entry) ? period_reg - tab_entry
                                               : tab_entry - period_reg;
  assign accept    = (min_reg <= (period_reg >> 5)) && (period_reg >= MIN_PERIOD);

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= WAIT_EDGE;
      idx_reg     <= 4'd0;
      period_reg  <= 32'd0;
      min_reg     <= 32'd0;
      best_reg    <= 4'd0;
      cand_reg    <= 4'd0;
      stab_reg    <= 8'd0;
      note_sel    <= 4'd0;
      note_valid  <= 1'b0;
      note_change <= 1'b0;
      silence     <= 1'b1;
      period_meas <= 32'd0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      period_reg  <= period_next;
      min_reg     <= min_next;
      best_reg    <= best_next;
      cand_reg    <= cand_next;
      stab_reg    <= stab_next;
      note_sel    <= sel_next;
      note_valid  <= valid_next;
      note_change <= change_next;
      silence     <= silence_next;
      period_meas <= meas_next;
    end
  end

  // Classifier next-state and output logic; timeout overrides everything,
  // an edge during classification aborts it and restarts measuring
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    period_next  = period_reg;
    min_next     = min_reg;
    best_next    = best_reg;
    cand_next    = cand_reg;
    stab_next    = stab_reg;
    sel_next     = note_sel;
    valid_next   = note_valid;
    change_next  = 1'b0;
    silence_next = silence;
    meas_next    = period_meas;
    stab_cnt     = 8'd0;

    if (edge_det) silence_next = 1'b0;

    if (timeout) begin
      state_next   = WAIT_EDGE;
      silence_next = 1'b1;
      valid_next   = 1'b0;
      stab_next    = 8'd0;
    end else begin
      case (state_reg)
        WAIT_EDGE: begin
          if (edge_det) state_next = MEASURE;
        end
        MEASURE: begin
          if (edge_det) begin
            period_next = meter_period;
            meas_next   = meter_period;
            idx_next    = 4'd0;
            state_next  = CLASSIFY;
          end
        end
        CLASSIFY: begin
          if (edge_det) begin
            stab_next  = 8'd0;
            state_next = MEASURE;
          end else begin
            if (idx_reg == 4'd0 || diff < min_reg) begin
              min_next  = diff;
              best_next = idx_reg;
            end
            if (idx_reg == LAST_IDX) state_next = DECIDE;
            else                     idx_next   = idx_reg + 4'd1;
          end
        end
        DECIDE: begin
          state_next = MEASURE;
          if (edge_det) begin
            stab_next = 8'd0;
          end else if (accept) begin
            if (stab_reg != 8'd0 && best_reg == cand_reg)
              stab_cnt = (stab_reg >= STAB_MAX) ? STAB_MAX : stab_reg + 8'd1;
            else
              stab_cnt = 8'd1;
            stab_next = stab_cnt;
            cand_next = best_reg;
            if (stab_cnt == STAB_MAX && (best_reg != note_sel || !note_valid)) begin
              sel_next    = best_reg;
              valid_next  = 1'b1;
              change_next = 1'b1;
            end
          end else begin
            stab_next  = 8'd0;
            valid_next = 1'b0;
          end
        end
        default: state_next = WAIT_EDGE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector at a 1.2 MHz clock so every scenario fits
// in a short run. Period table at 1.2 MHz: A4=2727, C6=1146, B5=1214,
// D6=1021 (MIN_PERIOD 510), C4=4580 (TIMEOUT 9160).
module tb_tone_detector;

  localparam int unsigned CLK_HZ = 1200000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        audio_in = 1'b0;
  logic [3:0]  note_sel;
  logic        note_valid;
  logic        note_change;
  logic        silence;
  logic [31:0] period_meas;

  tone_detector #(.CLOCK_FREQ(CLK_HZ), .STABLE_COUNT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .audio_in    (audio_in),
    .note_sel    (note_sel),
    .note_valid  (note_valid),
    .note_change (note_change),
    .silence     (silence),
    .period_meas (period_meas)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int chg_cnt = 0;

  // Count note_change pulses, sampled away from the active edge
  always @(negedge clk) if (note_change) chg_cnt++;

  typedef struct {
    int unsigned period;   // cycles from this rising edge to the next one
    logic [3:0]  sel;      // expected outputs ~22 cycles after this edge
    logic        valid;
    logic [31:0] meas;
    int          chg;      // expected cumulative note_change pulses
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int hi;

  initial begin
    // Edge i measures the period of row i-1 and drives the decision shown in row i
    vecs[0]  = '{2727, 4'd0,  1'b0, 32'd0,    0}; // first edge: no classification
    vecs[1]  = '{2727, 4'd0,  1'b0, 32'd2727, 0}; // A4 stab 1
    vecs[2]  = '{2727, 4'd0,  1'b0, 32'd2727, 0}; // A4 stab 2
    vecs[3]  = '{1146, 4'd5,  1'b1, 32'd2727, 1}; // A4 stab 3 -> lock
    vecs[4]  = '{1146, 4'd5,  1'b1, 32'd1146, 1}; // C6 #1, held
    vecs[5]  = '{1146, 4'd5,  1'b1, 32'd1146, 1}; // C6 #2, held
    vecs[6]  = '{2815, 4'd14, 1'b1, 32'd1146, 2}; // C6 #3 -> lock 14
    vecs[7]  = '{2600, 4'd14, 1'b0, 32'd2815, 2}; // 2815: diff 88 > tol 87, reject
    vecs[8]  = '{1180, 4'd14, 1'b0, 32'd2600, 2}; // 2600: diff 127 > tol 81, reject
    vecs[9]  = '{1180, 4'd14, 1'b0, 32'd1180, 2}; // 1180: tie 34/34 -> B5 (13)
    vecs[10] = '{1180, 4'd14, 1'b0, 32'd1180, 2};
    vecs[11] = '{2814, 4'd13, 1'b1, 32'd1180, 3}; // lock B5
    vecs[12] = '{2814, 4'd13, 1'b1, 32'd2814, 3}; // 2814: diff 87 = tol, A4 stab 1
    vecs[13] = '{2814, 4'd13, 1'b1, 32'd2814, 3}; // A4 stab 2, still B5

    // Reset with no input
    tick(3);
    check("rst_sel", note_sel, 0);
    check("rst_valid", note_valid, 0);
    check("rst_silence", silence, 1);
    check("rst_meas", period_meas, 0);
    rst_n = 1'b1;
    tick(5);
    check("idle_sel", note_sel, 0);
    check("idle_valid", note_valid, 0);
    check("idle_silence", silence, 1);
    check("idle_meas", period_meas, 0);
    check("idle_change", note_change, 0);

    // Table-driven periods
    for (int i = 0; i < 14; i++) begin
      hi = int'(vecs[i].period / 2);
      audio_in = 1'b1;
      tick(24);
      check($sformatf("row%0d_sel", i), note_sel, vecs[i].sel);
      check($sformatf("row%0d_valid", i), note_valid, vecs[i].valid);
      check($sformatf("row%0d_meas", i), period_meas, vecs[i].meas);
      check($sformatf("row%0d_silence", i), silence, 0);
      check($sformatf("row%0d_chg", i), chg_cnt, vecs[i].chg);
      $display("row %0d: next_period=%0d sel=%0d valid=%0d meas=%0d changes=%0d",
               i, vecs[i].period, note_sel, note_valid, period_meas, chg_cnt);
      tick(hi - 24);
      audio_in = 1'b0;
      tick(int'(vecs[i].period) - hi);
    end

    // Third 2814 period locks A4; check exact E+18 output timing
    audio_in = 1'b1;
    tick(19);                             // cycle E+17
    check("lock_e17_change", note_change, 0);
    check("lock_e17_sel", note_sel, 13);
    tick(1);                              // cycle E+18
    check("lock_e18_change", note_change, 1);
    check("lock_e18_sel", note_sel, 5);
    check("lock_e18_valid", note_valid, 1);
    tick(1);                              // cycle E+19
    check("lock_e19_change", note_change, 0);
    check("lock_chg_cnt", chg_cnt, 4);
    $display("lock A4: sel=%0d valid=%0d meas=%0d", note_sel, note_valid, period_meas);
    tick(1407 - 21);
    audio_in = 1'b0;

    // Input stops: silence exactly TIMEOUT cycles after the last edge
    tick(9161 - 1407);                    // cycle E+9159
    check("to_before_silence", silence, 0);
    check("to_before_valid", note_valid, 1);
    tick(1);                              // cycle E+9160
    check("to_silence", silence, 1);
    check("to_valid", note_valid, 0);
    check("to_sel", note_sel, 5);
    $display("timeout: silence=%0d valid=%0d sel=%0d", silence, note_valid, note_sel);

    // Next edge clears silence without producing a measurement
    audio_in = 1'b1;
    tick(2);                              // cycle E
    check("wake_e_silence", silence, 1);
    tick(1);                              // cycle E+1
    check("wake_silence", silence, 0);
    check("wake_meas", period_meas, 2814);
    $display("wake: silence=%0d meas=%0d", silence, period_meas);
    tick(1363 - 3);
    audio_in = 1'b0;
    tick(2727 - 1363);

    // Reset in the middle of classification
    audio_in = 1'b1;
    tick(7);                              // cycle E+5, classifying
    rst_n = 1'b0;
    tick(1);
    check("midrst_sel", note_sel, 0);
    check("midrst_valid", note_valid, 0);
    check("midrst_silence", silence, 1);
    check("midrst_meas", period_meas, 0);
    tick(20);
    check("midrst_hold_valid", note_valid, 0);
    check("midrst_chg", chg_cnt, 4);
    $display("mid-classify reset: sel=%0d valid=%0d silence=%0d meas=%0d",
             note_sel, note_valid, silence, period_meas);
    tick(1363 - 28);
    audio_in = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2727 - 1363 - 1);

    // Re-acquire A4: lock only on the 4th edge after reset
    for (int k = 1; k <= 4; k++) begin
      audio_in = 1'b1;
      tick(24);
      check($sformatf("relock%0d_valid", k), note_valid, (k == 4) ? 1 : 0);
      check($sformatf("relock%0d_sel", k), note_sel, (k == 4) ? 5 : 0);
      check($sformatf("relock%0d_meas", k), period_meas, (k == 1) ? 0 : 2727);
      check($sformatf("relock%0d_chg", k), chg_cnt, (k == 4) ? 5 : 4);
      $display("relock edge %0d: sel=%0d valid=%0d meas=%0d", k, note_sel, note_valid, period_meas);
      tick(1363 - 24);
      audio_in = 1'b0;
      tick(2727 - 1363);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
